// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and requester grant IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic gnt_t;

    localparam gnt_t GNT_IF = 1'b0;
    localparam gnt_t GNT_D  = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog counter for the BUSY state: counts enabled cycles, saturates, flags the last allowed cycle.
module mem_arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != CNT_W'(TIMEOUT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // High during the cycle whose increment brings the count to TIMEOUT.
    assign expired = enable && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data requesters, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN: alternate on simultaneous requests; otherwise data wins ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    state_t state_reg;
    gnt_t   gnt_reg;
    gnt_t   gnt_sel;
    logic   timer_expired;
    logic   any_req;

    assign any_req = if_req || d_req;

`ifdef ARB_ROUND_ROBIN_EN
    gnt_t last_grant_reg;

    always_comb begin
        gnt_sel = d_req ? GNT_D : GNT_IF;
        if (if_req && d_req) begin
            gnt_sel = (last_grant_reg == GNT_IF) ? GNT_D : GNT_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_reg <= GNT_IF;
        end else if (state_reg == ST_IDLE && any_req) begin
            last_grant_reg <= gnt_sel;
        end
    end
`else
    always_comb begin
        gnt_sel = d_req ? GNT_D : GNT_IF;
    end
`endif

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_reg == ST_IDLE),
        .enable  (state_reg == ST_BUSY),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= GNT_IF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            if_ready  <= 1'b0;
            if_err    <= 1'b0;
            d_rdata   <= '0;
            d_ready   <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_reg   <= gnt_sel;
                        mem_req   <= 1'b1;
                        state_reg <= ST_BUSY;
                        if (gnt_sel == GNT_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_be    <= '1;
                        end
                    end
                end
                ST_BUSY: begin
                    // mem_ready takes precedence over a coincident timeout.
                    if (mem_ready || timer_expired) begin
                        mem_req   <= 1'b0;
                        state_reg <= ST_DONE;
                        if (gnt_reg == GNT_D) begin
                            d_ready <= 1'b1;
                            d_err   <= !mem_ready;
                            d_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            if_ready <= 1'b1;
                            if_err   <= !mem_ready;
                            if_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
                ST_DONE: begin
                    if_rdata  <= '0;
                    if_ready  <= 1'b0;
                    if_err    <= 1'b0;
                    d_rdata   <= '0;
                    d_ready   <= 1'b0;
                    d_err     <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; grant order in the contention test follows ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        logic exp_d;

        reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ready = 1'b0;
        step(); step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        reset = 1'b1;
        step();

        // 1: fetch with memory answering two cycles after mem_req rises
        if_req = 1'b1; if_addr = 32'h10;
        step();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_be", mem_be, 4'hF);
        chk("t1_mem_wdata", mem_wdata, 0);
        step();
        chk("t1_mem_req_c2", mem_req, 1);
        step();
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        chk("t1_ready_early", if_ready, 0);
        step();
        chk("t1_if_ready", if_ready, 1);
        chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("t1_if_err", if_err, 0);
        chk("t1_d_ready", d_ready, 0);
        chk("t1_mem_req_done", mem_req, 0);
        mem_ready = 1'b0; if_req = 1'b0;
        step();
        chk("t1_if_ready_clr", if_ready, 0);
        chk("t1_if_rdata_clr", if_rdata, 0);

        // 2: simultaneous store and fetch; data wins (last grant was IF in both modes)
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'h3;
        if_req = 1'b1; if_addr = 32'h44;
        step();
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_be", mem_be, 4'h3);
        chk("t2_mem_addr", mem_addr, 32'h200);
        chk("t2_mem_wdata", mem_wdata, 32'h12345678);
        mem_ready = 1'b1; mem_rdata = 32'hAAAA5555;
        step();
        chk("t2_d_ready", d_ready, 1);
        chk("t2_d_rdata", d_rdata, 32'hAAAA5555);
        chk("t2_if_ready", if_ready, 0);
        mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        chk("t2_idle_mem_req", mem_req, 0);
        chk("t2_idle_d_ready", d_ready, 0);
        step();
        chk("t2_if_mem_addr", mem_addr, 32'h44);
        chk("t2_if_mem_we", mem_we, 0);
        chk("t2_if_mem_be", mem_be, 4'hF);
        chk("t2_if_mem_wdata", mem_wdata, 0);
        mem_ready = 1'b1; mem_rdata = 32'h11112222;
        step();
        chk("t2_if_ready", if_ready, 1);
        chk("t2_if_rdata", if_rdata, 32'h11112222);
        mem_ready = 1'b0; if_req = 1'b0;
        step();

        // 3: both requests held for four transactions, memory answers at once
        if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_addr = 32'h300; d_be = 4'hF;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            mem_rdata = 32'h100 + i;
            step();
            chk($sformatf("t3_addr_%0d", i), mem_addr, exp_d ? 32'h300 : 32'h80);
            step();
            chk($sformatf("t3_d_ready_%0d", i), d_ready, exp_d);
            chk($sformatf("t3_if_ready_%0d", i), if_ready, !exp_d);
            chk($sformatf("t3_rdata_%0d", i), exp_d ? d_rdata : if_rdata, 32'h100 + i);
            step();
        end
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        step(); step(); step();

        // 4a: memory never answers -> watchdog abort after 15 BUSY cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_rdata = 32'hFFFF0000;
        step();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            cnt++;
            step();
        end
        chk("t4_busy_cycles", cnt, 15);
        chk("t4_d_ready", d_ready, 1);
        chk("t4_d_err", d_err, 1);
        chk("t4_d_rdata", d_rdata, 0);
        d_req = 1'b0;
        step();
        chk("t4_d_err_clr", d_err, 0);

        // 4b: mem_ready on the 15th BUSY cycle wins over the timeout
        d_req = 1'b1;
        step();
        for (int i = 0; i < 14; i++) step();
        chk("t4b_mem_req_c15", mem_req, 1);
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        chk("t4b_d_ready", d_ready, 1);
        chk("t4b_d_err", d_err, 0);
        chk("t4b_d_rdata", d_rdata, 32'h0BADF00D);
        mem_ready = 1'b0; d_req = 1'b0;
        step();

        // 5: reset mid-transaction, then stray mem_ready
        if_req = 1'b1; if_addr = 32'h500;
        step();
        chk("t5_mem_req", mem_req, 1);
        reset = 1'b0;
        step();
        chk("t5_rst_mem_req", mem_req, 0);
        chk("t5_rst_mem_addr", mem_addr, 0);
        chk("t5_rst_mem_be", mem_be, 0);
        reset = 1'b1; if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h77;
        step();
        chk("t5_if_ready_a", if_ready, 0);
        step();
        chk("t5_if_ready_b", if_ready, 0);
        chk("t5_if_rdata", if_rdata, 0);
        chk("t5_mem_req_idle", mem_req, 0);

        // 6: mem_ready tied high with fetch held -> 3-cycle cadence
        if_req = 1'b1; if_addr = 32'h20; mem_rdata = 32'h66;
        step();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t6_mem_req_%0d", i), mem_req, (i % 3 == 0));
            chk($sformatf("t6_if_ready_%0d", i), if_ready, (i % 3 == 1));
            step();
        end
        if_req = 1'b0; mem_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
